aes_lane_scheduler: RTL and testbench



---
 rtl/aes_sched_pkg.sv | 21 ++
 rtl/aes_sched_timer.sv | 27 ++
 rtl/aes_lane_scheduler.sv | 164 ++++++++++++++++
 tb/tb_aes_lane_scheduler.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_sched_pkg.sv
// Shared types and defaults for the AES lane batching scheduler.
package aes_sched_pkg;

    localparam int DEF_LANES = 32;
    localparam int DEF_BLK_W = 128;

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } sched_state_t;

    // Extract one lane from a default-sized wide bus.
    function automatic logic [DEF_BLK_W-1:0] lane_slice(
        input logic [DEF_LANES*DEF_BLK_W-1:0] bus,
        input int unsigned                    idx
    );
        return bus[idx*DEF_BLK_W +: DEF_BLK_W];
    endfunction

endpackage

// File: rtl/aes_sched_timer.sv
// Loadable down-counter that saturates at zero and flags when it is empty.
module aes_sched_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (en && (count_reg != '0)) begin
            count_reg <= count_reg - W'(1);
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/aes_lane_scheduler.sv
// Packs a block stream into encryptor lanes, waits the array latency,
// then drains the captured results back out in lane order.
module aes_lane_scheduler
    import aes_sched_pkg::*;
#(
    parameter int LANES         = DEF_LANES,
    parameter int BLK_W         = DEF_BLK_W,
    parameter int ENC_LATENCY   = 10,
    parameter int FLUSH_TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [BLK_W-1:0]       in_data,
    input  logic                   in_last,
    output logic [LANES*BLK_W-1:0] enc_in,
    input  logic [LANES*BLK_W-1:0] enc_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [BLK_W-1:0]       out_data,
    output logic                   out_last,
    output logic                   busy,
    output logic [15:0]            batch_cnt
);

    localparam int CNT_W  = $clog2(LANES + 1);
    localparam int LAT_W  = (ENC_LATENCY > 0) ? $clog2(ENC_LATENCY + 1) : 1;
    localparam int IDLE_W = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;
    // Idle timer is loaded one short so the dispatch lands on the Nth idle edge.
    localparam int IDLE_LOAD = (FLUSH_TIMEOUT > 0) ? FLUSH_TIMEOUT - 1 : 0;

    sched_state_t     state_reg;
    logic [CNT_W-1:0] fill_cnt_reg;
    logic [CNT_W-1:0] drain_idx_reg;
    logic [CNT_W-1:0] n_valid_reg;
    logic             last_flag_reg;
    logic [15:0]      batch_cnt_reg;
    logic [BLK_W-1:0] staging_reg [LANES];
    logic [BLK_W-1:0] result_reg  [LANES];

    logic accept;
    logic fill_done;
    logic flush_fire;
    logic capture;
    logic beat;
    logic drain_done;
    logic lat_zero;
    logic idle_zero;
    logic in_fill;

    assign in_fill    = (state_reg == S_FILL);
    assign in_ready   = in_fill && (fill_cnt_reg < CNT_W'(LANES));
    assign accept     = in_valid && in_ready;
    assign fill_done  = accept && ((fill_cnt_reg + CNT_W'(1) == CNT_W'(LANES)) || in_last);
    assign flush_fire = (FLUSH_TIMEOUT != 0) && in_fill && (fill_cnt_reg != '0)
                        && !accept && idle_zero;
    assign capture    = (state_reg == S_WAIT) && lat_zero;
    assign out_valid  = (state_reg == S_DRAIN);
    assign beat       = out_valid && out_ready;
    assign drain_done = beat && (drain_idx_reg + CNT_W'(1) == n_valid_reg);

    aes_sched_timer #(.W(LAT_W)) u_lat_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (in_fill && (fill_done || flush_fire)),
        .load_val (LAT_W'(ENC_LATENCY)),
        .en       (state_reg == S_WAIT),
        .zero     (lat_zero)
    );

    aes_sched_timer #(.W(IDLE_W)) u_idle_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (IDLE_W'(IDLE_LOAD)),
        .en       (in_fill && (fill_cnt_reg != '0) && !accept),
        .zero     (idle_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_FILL;
            fill_cnt_reg  <= '0;
            drain_idx_reg <= '0;
            n_valid_reg   <= '0;
            last_flag_reg <= 1'b0;
            batch_cnt_reg <= '0;
        end else begin
            case (state_reg)
                S_FILL: begin
                    if (accept) begin
                        fill_cnt_reg <= fill_cnt_reg + CNT_W'(1);
                    end
                    if (fill_done) begin
                        state_reg     <= S_WAIT;
                        last_flag_reg <= in_last;
                    end else if (flush_fire) begin
                        state_reg     <= S_WAIT;
                        last_flag_reg <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (capture) begin
                        n_valid_reg   <= fill_cnt_reg;
                        drain_idx_reg <= '0;
                        batch_cnt_reg <= batch_cnt_reg + 16'd1;
                        state_reg     <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (drain_done) begin
                        state_reg     <= S_FILL;
                        fill_cnt_reg  <= '0;
                        drain_idx_reg <= '0;
                        last_flag_reg <= 1'b0;
                    end else if (beat) begin
                        drain_idx_reg <= drain_idx_reg + CNT_W'(1);
                    end
                end
                default: state_reg <= S_FILL;
            endcase
        end
    end

    // Staging doubles as the encryptor input bus, so it stays frozen until drain ends.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                staging_reg[gi] <= '0;
            end else if (drain_done) begin
                staging_reg[gi] <= '0;
            end else if (accept && (fill_cnt_reg == CNT_W'(gi))) begin
                staging_reg[gi] <= in_data;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                result_reg[gi] <= '0;
            end else if (capture) begin
                result_reg[gi] <= enc_out[gi*BLK_W +: BLK_W];
            end
        end

        assign enc_in[gi*BLK_W +: BLK_W] = staging_reg[gi];
    end

    always_comb begin
        out_data = '0;
        if (out_valid) begin
            for (int i = 0; i < LANES; i++) begin
                if (drain_idx_reg == CNT_W'(i)) begin
                    out_data = result_reg[i];
                end
            end
        end
    end

    assign out_last  = out_valid && last_flag_reg && (drain_idx_reg + CNT_W'(1) == n_valid_reg);
    assign busy      = !in_fill || (fill_cnt_reg != '0);
    assign batch_cnt = batch_cnt_reg;

endmodule

// File: tb/tb_aes_lane_scheduler.sv
// Directed bench for aes_lane_scheduler with a 3-stage XOR encryptor model.
module tb_aes_lane_scheduler;
    import aes_sched_pkg::*;

    localparam int LANES = 32;
    localparam int BLK_W = 128;
    localparam int LAT   = 3;
    localparam int FTO   = 8;
    localparam logic [BLK_W-1:0] KEY = {16{8'hA5}};

    logic                   clk;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [BLK_W-1:0]       in_data;
    logic                   in_last;
    logic [LANES*BLK_W-1:0] enc_in;
    logic [LANES*BLK_W-1:0] enc_out;
    logic                   out_valid;
    logic                   out_ready;
    logic [BLK_W-1:0]       out_data;
    logic                   out_last;
    logic                   busy;
    logic [15:0]            batch_cnt;

    aes_lane_scheduler #(
        .LANES         (LANES),
        .BLK_W         (BLK_W),
        .ENC_LATENCY   (LAT),
        .FLUSH_TIMEOUT (FTO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .enc_in    (enc_in),
        .enc_out   (enc_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .batch_cnt (batch_cnt)
    );

    // Encryptor array model: three register stages of per-lane XOR with KEY.
    logic [LANES*BLK_W-1:0] p1, p2, p3;
    always @(posedge clk) begin
        p1 <= enc_in ^ {LANES{KEY}};
        p2 <= p1;
        p3 <= p2;
    end
    assign enc_out = p3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic junk_on = 1'b0;
    logic [BLK_W-1:0] junk_val = 128'hDEAD_0000;
    int exp_batches = 0;

    typedef struct {
        int n;
        bit last;
        int base;
        int stall;
        bit junk;
        int exp_lat;
        bit exp_last;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (junk_on) begin
            junk_val = junk_val + 1;
            in_data  = junk_val;
        end
    endtask

    task automatic send(input logic [BLK_W-1:0] d, input logic l);
        int w;
        w        = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && w < 200) begin
            step();
            w++;
        end
        check("send_ready", BLK_W'(in_ready), 1);
        step();
        in_last = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            step();
            lat++;
        end
    endtask

    task automatic collect(input int n, input int base, input bit exp_last, input int stall);
        int idx;
        int cyc;
        logic r;
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 3000) begin
            r = (stall == 0) ? 1'b1 : (cyc >= 10 && (cyc % 2) == 0);
            out_ready = r;
            check("out_valid", BLK_W'(out_valid), 1);
            if (!out_valid) break;
            check("in_ready_drain", BLK_W'(in_ready), 0);
            check("busy_drain", BLK_W'(busy), 1);
            check(r ? "out_data" : "stall_data", out_data, BLK_W'(base + idx) ^ KEY);
            if (r) begin
                check("out_last", BLK_W'(out_last), BLK_W'(exp_last && idx == n - 1));
                idx++;
            end
            step();
            cyc++;
        end
        out_ready = 1'b0;
        check("beats", BLK_W'(idx), BLK_W'(n));
        check("valid_drop", BLK_W'(out_valid), 0);
        check("in_ready_after", BLK_W'(in_ready), 1);
        check("busy_after", BLK_W'(busy), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int k;

        vecs[0] = '{n: 32, last: 1'b0, base: 'h000, stall: 0, junk: 1'b0, exp_lat: 4, exp_last: 1'b0};
        vecs[1] = '{n: 5,  last: 1'b1, base: 'h100, stall: 0, junk: 1'b0, exp_lat: 4, exp_last: 1'b1};
        vecs[2] = '{n: 32, last: 1'b0, base: 'h200, stall: 1, junk: 1'b0, exp_lat: 4, exp_last: 1'b0};
        vecs[3] = '{n: 4,  last: 1'b1, base: 'h300, stall: 0, junk: 1'b1, exp_lat: 4, exp_last: 1'b1};
        vecs[4] = '{n: 2,  last: 1'b1, base: 'h400, stall: 0, junk: 1'b0, exp_lat: 4, exp_last: 1'b1};

        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #1 rst = 1'b1;
        #2;
        check("rst_in_ready",  BLK_W'(in_ready), 1);
        check("rst_out_valid", BLK_W'(out_valid), 0);
        check("rst_busy",      BLK_W'(busy), 0);
        check("rst_batch_cnt", BLK_W'(batch_cnt), 0);
        check("rst_enc_in",    BLK_W'(enc_in == '0), 1);
        #9 rst = 1'b0;
        step();

        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < vecs[v].n; i++) begin
                send(BLK_W'(vecs[v].base + i), vecs[v].last && (i == vecs[v].n - 1));
            end
            check("in_ready_post", BLK_W'(in_ready), 0);
            check("enc_lane_last", lane_slice(enc_in, vecs[v].n - 1), BLK_W'(vecs[v].base + vecs[v].n - 1));
            if (vecs[v].n < LANES) begin
                check("enc_upper_zero", BLK_W'((enc_in >> (vecs[v].n * BLK_W)) == '0), 1);
            end
            if (vecs[v].junk) begin
                junk_on  = 1'b1;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            wait_valid(lat);
            check("latency", BLK_W'(lat), BLK_W'(vecs[v].exp_lat));
            collect(vecs[v].n, vecs[v].base, vecs[v].exp_last, vecs[v].stall);
            junk_on  = 1'b0;
            in_valid = 1'b0;
            exp_batches++;
            check("batch_cnt", BLK_W'(batch_cnt), BLK_W'(exp_batches));
            $display("batch %0d: blocks=%0d last=%0d stall=%0d junk=%0d latency=%0d batch_cnt=%0d",
                     v, vecs[v].n, vecs[v].last, vecs[v].stall, vecs[v].junk, lat, batch_cnt);
        end

        // Partial batch dispatched by the idle timeout.
        for (int i = 0; i < 3; i++) send(BLK_W'('h500 + i), 1'b0);
        in_valid = 1'b0;
        k = 0;
        while (in_ready && k < 50) begin
            check("busy_idle", BLK_W'(busy), 1);
            step();
            k++;
        end
        check("flush_edge", BLK_W'(k), 8);
        wait_valid(lat);
        check("flush_latency", BLK_W'(lat), 4);
        collect(3, 'h500, 1'b0, 0);
        exp_batches++;
        check("flush_batch_cnt", BLK_W'(batch_cnt), BLK_W'(exp_batches));
        $display("flush batch: blocks=3 idle_edges=%0d latency=%0d batch_cnt=%0d", k, lat, batch_cnt);

        // Reset asserted while lat_cnt==1 discards the in-flight batch.
        for (int i = 0; i < 3; i++) send(BLK_W'('h600 + i), i == 2);
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        check("rst_mid_out_valid", BLK_W'(out_valid), 0);
        check("rst_mid_batch_cnt", BLK_W'(batch_cnt), 0);
        check("rst_mid_in_ready",  BLK_W'(in_ready), 1);
        check("rst_mid_busy",      BLK_W'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("rst_rel_in_ready", BLK_W'(in_ready), 1);
        for (int i = 0; i < 2; i++) send(BLK_W'('h700 + i), i == 1);
        in_valid = 1'b0;
        wait_valid(lat);
        check("rst_latency", BLK_W'(lat), 4);
        collect(2, 'h700, 1'b1, 0);
        check("rst_batch_cnt_after", BLK_W'(batch_cnt), 1);
        $display("reset batch: blocks=2 latency=%0d batch_cnt=%0d", lat, batch_cnt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
